mpmc11_resv_mgr: RTL
====================

# mpmc11_resv_mgr

Reservation table manager for the mpmc11 multi-port memory controller. Accepts load-reserve requests from up to NCH channels, arbitrates them round-robin, and allocates, replaces or clears the NAR reservation entries. It invalidates every entry whose 32-byte line is hit by a committed write. Its `resv_ch`/`resv_adr` arrays feed the per-channel reservation-bit logic that evaluates store-conditional success.

## Interface
Parameters:
- `NAR`, 4: number of reservation entries (power of two, 2..16).
- `NCH`, 8: number of requesting channels (1..15); channel id 4'hF is reserved to mean "no owner".

Ports:
- `clk`  in  1  controller clock; all state changes on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `set_req`  in  NCH  per-channel load-reserve request; held until `set_ack`.
- `set_adr`  in  [31:0] x NCH (unpacked `[0:NCH-1]`)  reservation address per channel; stable while `set_req` is high.
- `set_ack`  out  NCH  one-cycle grant pulse per channel.
- `wr_v`  in  1  a write committed to memory this cycle.
- `wr_ch`  in  4  channel issuing the committed write.
- `wr_adr`  in  32  committed write address.
- `resv_ch`  out  [3:0] x NAR (`[0:NAR-1]`)  owner channel per entry; 4'hF when invalid.
- `resv_adr`  out  [31:0] x NAR (`[0:NAR-1]`)  reserved address per entry; 0 when invalid.
- `resv_v`  out  NAR  entry valid bits.
- `full`  out  1  all entries valid.

## Operation
- Line match: entry i matches address A when `resv_v[i]` is set and `resv_adr[i][31:5]==A[31:5]`.
- Arbitration:
  - Eligible channels are `set_req & ~set_ack`. The currently acked channel is masked so a held request is never granted twice.
  - Round-robin priority pointer `rr` (width clog2(NCH)). Grant goes to the first eligible channel at or above `rr`, wrapping.
  - On a grant to channel g, `rr` becomes g+1, wrapping to 0 after NCH-1.
  - At most one grant per cycle.
- Allocation for granted channel g with address A, in priority order:
  1. If g already owns a valid entry, overwrite that entry. Each channel holds at most one reservation.
  2. Else use the lowest-index invalid entry.
  3. Else evict the victim entry (see Configuration).
  - The written entry becomes `resv_ch=g`, `resv_adr=A`, `resv_v=1`.
- Write clear: when `wr_v` is high, every line-matching entry is cleared to `resv_v=0`, `resv_ch=4'hF`, `resv_adr=0`, regardless of `wr_ch`.
- Simultaneous grant and write in the same cycle: the grant is ordered after the write.
  - Matching existing entries are cleared.
  - The newly written entry is valid even if its line matches `wr_adr`.
  - If the grant targets an entry that the write would clear, the grant's write wins.
- `full` = AND of `resv_v`, registered alongside the entries.

## Timing
- Reset (async assert, synchronous-to-`clk` release):
  - `resv_v=0`, `resv_ch` all 4'hF, `resv_adr` all 0.
  - `set_ack=0`, `full=0`, `rr=0`, victim pointer 0.
- Grant latency: `set_req` high at edge N is decided combinationally. At edge N the entry is updated and `set_ack[g]` rises. Both are visible in cycle N+1.
- `set_ack` is high for exactly one cycle. The requester drops `set_req` in the cycle `set_ack` is seen. If `set_req` is still high the cycle after, it counts as a new request.
- Write clear latency: `wr_v` at edge N clears the entries, visible in cycle N+1.
- Reset mid-operation: pending requests are dropped without ack; requesters must re-request after `rstn` deasserts.
- Throughput: one reservation per cycle; a contended channel waits at most NCH-1 grants.

## Configuration
- `MPMC11_RESV_RR_EVICT_EN` defined:
  - The victim is a clog2(NAR)-bit round-robin pointer. It advances by one, wrapping NAR-1 to 0, only on an eviction (allocation case 3).
- Not defined:
  - The victim is always entry NAR-1.
  - No victim pointer register exists.

## Test plan
- Reset: drive `rstn=0` mid-grant -> `resv_v=0`, all `resv_ch=4'hF`, `set_ack=0` on the next sampled cycle without waiting for `clk`.
- Single set: ch2 requests 0x1000_0040 -> cycle N+1 `set_ack[2]=1`, entry 0 = {ch 2, 0x1000_0040, valid}, `set_ack` low in N+2.
- Fairness: ch0, ch3 and ch5 request continuously with `rr=0` -> grants in order 0, 3, 5, 0 on consecutive cycles, with no double grant.
- Re-reserve: ch1 owns entry 0; ch1 requests 0x2000_0000 -> entry 0 is overwritten and no other entry is allocated.
- Write clear: entries hold 0x3000_0004 (ch1) and 0x3000_001C (ch4); `wr_v` with `wr_adr` 0x3000_0010 from ch1 -> both entries are invalid next cycle with `resv_ch=4'hF`.
- Full, NAR=4, macro defined: five distinct channels reserve -> the fifth replaces entry 0, and a sixth replaces entry 1. With the macro undefined, both replace entry 3.

Source files
------------

// File: rtl/mpmc11_resv_mgr.sv
// mpmc11_resv_mgr: reservation table manager for the mpmc11 memory controller.
// Arbitrates load-reserve requests from NCH channels round-robin, allocates,
// replaces or clears NAR reservation entries, and invalidates every entry
// whose 32-byte line is hit by a committed write.
// Optional feature macro: MPMC11_RESV_RR_EVICT_EN. When it is defined, the
// eviction victim is a rotating pointer. Otherwise the victim is always
// entry NAR-1.
module mpmc11_resv_mgr #(
  parameter int NAR = 4,
  parameter int NCH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NCH-1:0]   set_req,
  input  logic [31:0]      set_adr [0:NCH-1],
  output logic [NCH-1:0]   set_ack,
  input  logic             wr_v,
  input  logic [3:0]       wr_ch,
  input  logic [31:0]      wr_adr,
  output logic [3:0]       resv_ch [0:NAR-1],
  output logic [31:0]      resv_adr [0:NAR-1],
  output logic [NAR-1:0]   resv_v,
  output logic             full
);

  localparam int RRW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW  = RRW + 1;
  localparam int VW  = $clog2(NAR);

  logic [RRW-1:0] rr_reg;
  logic [RRW-1:0] rr_next;
  logic [NCH-1:0] elig;
  logic           gnt_v;
  logic [RRW-1:0] gnt_id;
  logic [IW-1:0]  idx;

  logic [NAR-1:0] clr_mask;
  logic [NAR-1:0] v_post;
  logic [NAR-1:0] own_hit;
  logic [VW-1:0]  tgt;
  logic [VW-1:0]  victim;
  logic           own_found;
  logic           free_found;
  logic           evict;

  logic [3:0]     ch_next  [0:NAR-1];
  logic [31:0]    adr_next [0:NAR-1];
  logic [NAR-1:0] v_next;

  // The write clears entries regardless of the issuing channel.
  // Only the line bits of the write address take part in matching.
  logic wr_unused;
  assign wr_unused = ^{wr_ch, wr_adr[4:0]};

  // A held request is masked while its ack is visible, so it is never granted twice.
  assign elig = set_req & ~set_ack;

  // Line match against the committed write. Matching entries are cleared
  // before the grant is placed, so the grant sees the post-write table.
  for (genvar gi = 0; gi < NAR; gi++) begin : g_match
    assign clr_mask[gi] = wr_v && resv_v[gi] && (resv_adr[gi][31:5] == wr_adr[31:5]);
    assign own_hit[gi]  = v_post[gi] && (resv_ch[gi] == 4'(gnt_id));
  end
  assign v_post = resv_v & ~clr_mask;

  // Round-robin search: the first eligible channel at or above rr, wrapping.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, rr_reg} + IW'(k);
      if (idx >= IW'(NCH)) begin
        idx = idx - IW'(NCH);
      end
      if (!gnt_v && elig[idx[RRW-1:0]]) begin
        gnt_v  = 1'b1;
        gnt_id = idx[RRW-1:0];
      end
    end
  end

  // Pointer moves just past the winner so the winner becomes lowest priority.
  always_comb begin
    rr_next = rr_reg;
    if (gnt_v) begin
      rr_next = (gnt_id == RRW'(NCH - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Target selection: the channel's own entry, else the lowest free entry, else the victim.
  always_comb begin
    tgt        = '0;
    own_found  = 1'b0;
    free_found = 1'b0;
    for (int i = 0; i < NAR; i++) begin
      if (!own_found && own_hit[i]) begin
        own_found = 1'b1;
        tgt       = VW'(i);
      end
    end
    if (!own_found) begin
      for (int i = 0; i < NAR; i++) begin
        if (!free_found && !v_post[i]) begin
          free_found = 1'b1;
          tgt        = VW'(i);
        end
      end
    end
    if (!own_found && !free_found) begin
      tgt = victim;
    end
    evict = gnt_v && !own_found && !free_found;
  end

`ifdef MPMC11_RESV_RR_EVICT_EN
  logic [VW-1:0] vict_reg;

  // The victim pointer rotates only when an entry is actually evicted.
  // NAR is a power of two, so the pointer wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vict_reg <= '0;
    end else if (evict) begin
      vict_reg <= vict_reg + 1'b1;
    end
  end

  assign victim = vict_reg;
`else
  logic evict_unused;
  assign evict_unused = evict;
  assign victim       = VW'(NAR - 1);
`endif

  // Next table contents: apply the write clear first, then overlay the grant.
  always_comb begin
    for (int i = 0; i < NAR; i++) begin
      ch_next[i]  = clr_mask[i] ? 4'hF  : resv_ch[i];
      adr_next[i] = clr_mask[i] ? 32'h0 : resv_adr[i];
    end
    v_next = v_post;
    if (gnt_v) begin
      v_next[tgt]   = 1'b1;
      ch_next[tgt]  = 4'(gnt_id);
      adr_next[tgt] = set_adr[gnt_id];
    end
  end

  // Reservation table register, with full registered alongside it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NAR; i++) begin
        resv_ch[i]  <= 4'hF;
        resv_adr[i] <= '0;
      end
      resv_v <= '0;
      full   <= 1'b0;
    end else begin
      for (int i = 0; i < NAR; i++) begin
        resv_ch[i]  <= ch_next[i];
        resv_adr[i] <= adr_next[i];
      end
      resv_v <= v_next;
      full   <= &v_next;
    end
  end

  // Arbitration state and the one-cycle grant pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_reg  <= '0;
      set_ack <= '0;
    end else begin
      rr_reg  <= rr_next;
      set_ack <= gnt_v ? (NCH'(1) << gnt_id) : '0;
    end
  end

endmodule
